// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad scanner: matrix dimensions, the
//   scanner FSM state encoding and the column-drive helper.
//   No ports (package).
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // SCAN   : counting inside a column step
  // SAMPLE : last cycle of a step, rows captured, column advances
  // UPDATE : frame tick, doubles as the first cycle of column 0
  // HOLD   : scanner parked while scan_en is low
  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    SAMPLE = 2'd1,
    UPDATE = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  // Active-low one-hot column drive for column index col.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
    logic [NUM_COLS-1:0] one;
    one = 1;
    return ~(one << col);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Per-key frame-rate debouncer and press-edge detector.
//   Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat pulses while the
//   key stays pressed (REPEAT_DLY frames to the first repeat, then every
//   REPEAT_PER frames). Without it exactly one pulse is produced per press.
//   Ports:
//     clk   - clock, rising edge
//     rstn  - synchronous active-low reset
//     tick  - frame tick, one cycle per completed scan frame
//     raw   - sampled key level for the frame just completed (1 = pressed)
//     level - debounced key level (1 = pressed)
//     pulse - one-cycle pulse in the cycle after the tick that saw a press
module keypad_debounce #(
  parameter int DEB_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

  logic [3:0] deb_cnt_reg;
  logic       level_reg;
  logic       pulse_reg;
  logic       disagree;
  logic       flip;
  logic       press;

  assign disagree = (raw != level_reg);
  // The counter holds frames already seen in disagreement, so the flip
  // happens on the tick that would bring it to DEB_FRAMES.
  assign flip     = tick && disagree && (deb_cnt_reg == DEB_LAST);
  assign press    = flip && !level_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      deb_cnt_reg <= '0;
      level_reg   <= 1'b0;
    end else if (tick) begin
      if (!disagree) begin
        deb_cnt_reg <= '0;
      end else if (flip) begin
        deb_cnt_reg <= '0;
        level_reg   <= ~level_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 4'd1;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_cnt_reg;
  logic        rep_first_reg;
  logic [15:0] rep_target;
  logic        rep_run;
  logic        rep_hit;

  // Repeats only advance while the key is both debounced-pressed and seen
  // pressed this frame, so a release in progress stops them immediately.
  assign rep_run    = tick && level_reg && raw;
  assign rep_target = rep_first_reg ? 16'(REPEAT_DLY) : 16'(REPEAT_PER);
  assign rep_hit    = rep_run && ((rep_cnt_reg + 16'd1) == rep_target);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else if (press) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else if (rep_run) begin
      if (rep_hit) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) pulse_reg <= 1'b0;
    else       pulse_reg <= press | rep_hit;
  end
`else
  always_ff @(posedge clk) begin
    if (!rstn) pulse_reg <= 1'b0;
    else       pulse_reg <= press;
  end
`endif

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
//   4x4 matrix keypad scanner: drives one column low at a time, samples the
//   synchronized rows at the end of each column step, and debounces every
//   key once per frame (4*SCAN_DIV cycles).
//   Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat pulses.
//   Ports:
//     clk       - clock, rising edge
//     rstn      - synchronous active-low reset
//     scan_en   - high runs the scanner, low parks it with columns released
//     row_in    - matrix rows, asynchronous, active-low
//     col_out   - column drive, active-low one-hot (4'hF when parked)
//     key_state - debounced level per key, index row*4+col, 1 = pressed
//     key_pluse - one-cycle press pulse per key
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_pluse
);

  // An out-of-range configuration keeps the scanner parked in HOLD, which
  // makes the mistake obvious instead of silently mis-scanning.
  localparam bit PARAMS_OK = (SCAN_DIV >= 4) && (SCAN_DIV <= 65535) &&
                             (DEB_FRAMES >= 1) && (DEB_FRAMES <= 15) &&
                             (REPEAT_DLY >= 1) && (REPEAT_PER >= 1);

  // Step counter value in the cycle before SAMPLE.
  localparam logic [15:0] CNT_PRE = 16'(SCAN_DIV - 2);

  logic [NUM_ROWS-1:0] row_meta_reg;
  logic [NUM_ROWS-1:0] row_sync_reg;

  scan_state_t state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  col_reg, col_next;

  logic                run;
  logic                sample;
  logic                frame_tick;
  logic [NUM_KEYS-1:0] pulse_vec;

  assign run = scan_en & PARAMS_OK;

  // Two-flop row synchronizer; idles high like the pulled-up rows.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= SCAN;
      cnt_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
    end
  end

  // FSM: next state. UPDATE is also cycle 0 of column 0, so a frame is
  // exactly 4*SCAN_DIV cycles with no idle gap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    if (!run) begin
      state_next = HOLD;
      cnt_next   = '0;
      col_next   = '0;
    end else begin
      case (state_reg)
        HOLD: begin
          state_next = SCAN;
          cnt_next   = '0;
          col_next   = '0;
        end
        SAMPLE: begin
          cnt_next   = '0;
          col_next   = col_reg + 2'd1;
          state_next = (col_reg == 2'(NUM_COLS - 1)) ? UPDATE : SCAN;
        end
        default: begin
          cnt_next   = cnt_reg + 16'd1;
          state_next = (cnt_reg == CNT_PRE) ? SAMPLE : SCAN;
        end
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    col_out    = col_drive(col_reg);
    key_pluse  = pulse_vec;
    sample     = 1'b0;
    frame_tick = 1'b0;
    case (state_reg)
      HOLD: begin
        col_out   = '1;
        key_pluse = '0;
      end
      SAMPLE:  sample     = 1'b1;
      UPDATE:  frame_tick = 1'b1;
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      localparam int ROW = gi / NUM_COLS;
      localparam int COL = gi % NUM_COLS;

      logic raw_reg;

      // Captured on the last cycle of this key's column step.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          raw_reg <= 1'b0;
        end else if (sample && (col_reg == 2'(COL))) begin
          raw_reg <= ~row_sync_reg[ROW];
        end
      end

      keypad_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
`endif
      ) u_deb (
        .clk   (clk),
        .rstn  (rstn),
        .tick  (frame_tick),
        .raw   (raw_reg),
        .level (key_state[gi]),
        .pulse (pulse_vec[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_state;
  logic [15:0] key_pluse;
  logic [15:0] pressed = 16'h0000;

  int errors = 0;
  int checks = 0;
  int pulse_total = 0;
  int exp_total = 0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV   (8),
    .DEB_FRAMES (3),
    .REPEAT_DLY (4),
    .REPEAT_PER (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .scan_en   (scan_en),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_state (key_state),
    .key_pluse (key_pluse)
  );

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Counts every asserted pulse bit over the whole run.
  always @(negedge clk) pulse_total <= pulse_total + $countones(key_pluse);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_state;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the frame-tick cycle (column 3 -> column 0 transition).
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = col_out;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
      prev = col_out;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_sync: no frame boundary within 200 cycles, col_out=%h", col_out);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0020, 16'h0000, 16'h0000};
    vecs[1]  = '{16'h0020, 16'h0000, 16'h0000};
    vecs[2]  = '{16'h0020, 16'h0020, 16'h0020};
    vecs[3]  = '{16'h0020, 16'h0020, 16'h0000};
    vecs[4]  = '{16'h0000, 16'h0020, 16'h0000};
    vecs[5]  = '{16'h0000, 16'h0020, 16'h0000};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h0000};
    vecs[7]  = '{16'h0200, 16'h0000, 16'h0000};
    vecs[8]  = '{16'h0200, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h0000, 16'h0000, 16'h0000};
    vecs[10] = '{16'h0200, 16'h0000, 16'h0000};
    vecs[11] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[12] = '{16'h8001, 16'h0000, 16'h0000};
    vecs[13] = '{16'h8001, 16'h0000, 16'h0000};
    vecs[14] = '{16'h8001, 16'h8001, 16'h8001};
    vecs[15] = '{16'h0000, 16'h8001, 16'h0000};
    vecs[16] = '{16'h0000, 16'h8001, 16'h0000};
    vecs[17] = '{16'h0000, 16'h0000, 16'h0000};

    // Reset for 3 cycles, then column 0 is held exactly 8 cycles.
    rstn = 1'b0;
    scan_en = 1'b1;
    cyc(3);
    check("reset_col_out", {12'h000, col_out}, 16'h000E);
    check("reset_key_state", key_state, 16'h0000);
    check("reset_key_pluse", key_pluse, 16'h0000);
    rstn = 1'b1;
    cyc(7);
    check("col0_held_7", {12'h000, col_out}, 16'h000E);
    cyc(1);
    check("col1_after_8", {12'h000, col_out}, 16'h000D);
    $display("reset: col_out=%b key_state=%h", col_out, key_state);

    // Frame-level vector table: keys held for one frame, checked after its tick.
    wait_frame_start();
    cyc(2);
    for (int i = 0; i < 18; i++) begin
      pressed = vecs[i].keys;
      wait_frame_start();
      cyc(1);
      check($sformatf("vec%0d_state", i), key_state, vecs[i].exp_state);
      check($sformatf("vec%0d_pulse", i), key_pluse, vecs[i].exp_pulse);
      cyc(1);
      check($sformatf("vec%0d_pulse_gone", i), key_pluse, 16'h0000);
      $display("vec %0d: keys=%h key_state=%h key_pluse=%h", i, vecs[i].keys, key_state, key_pluse);
    end
    exp_total = 3;
    cyc(2);
    check("pulse_total_table", 16'(pulse_total), 16'(exp_total));

    // Key 3 physically held for 12 frames, then released.
    for (int f = 1; f <= 15; f++) begin
      logic [15:0] exp_s;
      logic [15:0] exp_p;
      pressed = (f <= 12) ? 16'h0008 : 16'h0000;
      wait_frame_start();
      cyc(1);
      exp_s = (f >= 3 && f < 15) ? 16'h0008 : 16'h0000;
      exp_p = (f == 3 || (REP_EN && (f == 7 || f == 9 || f == 11))) ? 16'h0008 : 16'h0000;
      check($sformatf("hold_f%0d_state", f), key_state, exp_s);
      check($sformatf("hold_f%0d_pulse", f), key_pluse, exp_p);
      $display("hold frame %0d: key_state=%h key_pluse=%h", f, key_state, key_pluse);
      cyc(1);
    end
    exp_total += REP_EN ? 4 : 1;
    cyc(2);
    check("pulse_total_hold", 16'(pulse_total), 16'(exp_total));

    // Press key 6 and debounce it, then drop scan_en mid column 2.
    pressed = 16'h0040;
    for (int f = 1; f <= 3; f++) begin
      wait_frame_start();
    end
    cyc(1);
    check("key6_state", key_state, 16'h0040);
    exp_total += 1;
    wait_frame_start();
    cyc(20);
    check("mid_col2", {12'h000, col_out}, 16'h000B);
    scan_en = 1'b0;
    cyc(1);
    check("hold_col_out", {12'h000, col_out}, 16'h000F);
    begin
      int bad;
      bad = 0;
      for (int n = 0; n < 19; n++) begin
        cyc(1);
        if (col_out != 4'hF || key_pluse != 16'h0000 || key_state != 16'h0040) bad++;
      end
      check("hold_bad_cycles", 16'(bad), 16'h0000);
    end
    scan_en = 1'b1;
    cyc(1);
    check("resume_col0", {12'h000, col_out}, 16'h000E);
    cyc(7);
    check("resume_col0_held", {12'h000, col_out}, 16'h000E);
    cyc(1);
    check("resume_col1", {12'h000, col_out}, 16'h000D);
    check("resume_key_state", key_state, 16'h0040);
    $display("enable: resumed col_out=%b key_state=%h", col_out, key_state);

    // Release key 6.
    pressed = 16'h0000;
    for (int f = 1; f <= 3; f++) begin
      wait_frame_start();
    end
    cyc(1);
    check("key6_released", key_state, 16'h0000);

    // Reset sampled in the frame-tick cycle that would flip key 12.
    pressed = 16'h1000;
    for (int f = 1; f <= 3; f++) begin
      wait_frame_start();
    end
    rstn = 1'b0;
    cyc(1);
    check("rst_mid_pulse", key_pluse, 16'h0000);
    check("rst_mid_state", key_state, 16'h0000);
    check("rst_mid_col_out", {12'h000, col_out}, 16'h000E);
    cyc(2);
    rstn = 1'b1;
    pressed = 16'h0000;
    for (int f = 1; f <= 3; f++) begin
      wait_frame_start();
    end
    cyc(2);
    check("post_reset_state", key_state, 16'h0000);
    check("pulse_total_final", 16'(pulse_total), 16'(exp_total));
    $display("reset mid-pulse: key_state=%h pulses=%0d", key_state, pulse_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per column step, legal range 4..65535.
REQ-002 SHALL have parameter DEB_FRAMES, default 4, consecutive frames of disagreement needed to flip a debounced key, legal range 1..15.
REQ-003 SHALL have parameter REPEAT_DLY, default 50, frames a key must be held before the first repeat pulse (used only with KEYPAD_REPEAT_EN).
REQ-004 SHALL have parameter REPEAT_PER, default 10, frames between repeat pulses (used only with KEYPAD_REPEAT_EN).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port scan_en, input, 1 bit: high runs the scanner.
REQ-008 SHALL have port row_in, input, 4 bits: matrix rows, asynchronous, pulled up, active-low.
REQ-009 SHALL have port col_out, output, 4 bits: column drive, active-low one-hot.
REQ-010 SHALL have port key_state, output, 16 bits: debounced level per key, 1 = pressed.
REQ-011 SHALL have port key_pluse, output, 16 bits: one-cycle press pulse per key, intended to feed the key-latch register.

Function
REQ-012 SHALL pass row_in through a two-flop synchronizer before any use.
REQ-013 SHALL step through columns 0,1,2,3 in order, holding each for SCAN_DIV cycles, with col_out = ~(4'b0001 << col).
REQ-014 SHALL sample the synchronized, inverted rows on the last cycle of each column step into raw[row*4+col].
REQ-015 SHALL define a frame as 4*SCAN_DIV cycles and SHALL perform the debounce update in the cycle after column 3 is sampled (frame tick).
REQ-016 SHALL keep a per-key counter: on a frame tick, raw equal to key_state clears the counter; raw differing increments it, and when the counter reaches DEB_FRAMES, key_state toggles and the counter clears.
REQ-017 SHALL assert key_pluse[i] for exactly one cycle, the cycle after the frame tick, when key_state[i] goes 0 to 1; a 1 to 0 change SHALL produce no pulse.
REQ-018 SHALL assert multiple key_pluse bits in the same cycle when several keys flip in the same frame; ghosting is not resolved.
REQ-019 FSM states: SCAN (counting within a step), SAMPLE (last cycle of a step, then advance the column), UPDATE (frame tick, then SCAN at column 0), HOLD (scan_en low).
REQ-020 SHALL, when scan_en is low, enter HOLD within 1 cycle: col_out = 4'hF, key_pluse = 0, key_state and the debounce counters retained, the partial frame discarded.
REQ-021 SHALL, when scan_en returns high, restart at column 0 with the step counter at 0.
REQ-022 SHALL wrap the step counter at SCAN_DIV-1 and the column index at 3 without any idle gap.

Reset
REQ-023 SHALL, in the cycle after rstn is sampled low, set col_out = 4'b1110, key_state = 0, key_pluse = 0, all counters = 0, synchronizers = 4'hF, and FSM state = SCAN at column 0.
REQ-024 SHALL, if reset is asserted mid-frame or mid-pulse, suppress any pending pulse; no pulse SHALL appear after reset.

Configuration
REQ-025 SHALL, with macro KEYPAD_REPEAT_EN defined, re-pulse a key whose key_state stays 1: first repeat REPEAT_DLY frames after the press pulse, then every REPEAT_PER frames, each repeat aligned to the cycle after a frame tick; release stops repeats.
REQ-026 SHALL, without KEYPAD_REPEAT_EN, emit exactly one pulse per press and contain no repeat counters.

Structure
REQ-027 SHALL place NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16 and the FSM state enum in a shared package keypad_pkg.
REQ-028 SHALL implement the per-key debounce counter and edge detection (plus the repeat counter under the macro) in sub-module keypad_debounce, instantiated 16 times.

Verification (SCAN_DIV=8, DEB_FRAMES=3, REPEAT_DLY=4, REPEAT_PER=2)
REQ-029 Reset check: hold rstn low 3 cycles -> col_out=4'b1110, key_state=0, key_pluse=0; col_out=4'b1101 exactly 8 cycles after release.
REQ-030 Single key: model key 5 (row 1 low whenever col_out[1] is low) -> key_state=16'h0020 after 3 frames; key_pluse=16'h0020 for exactly 1 cycle, then 0.
REQ-031 Bounce: key 9 pressed for 2 frames, then released -> key_state stays 0 and there are no pulses.
REQ-032 Simultaneous press: keys 0 and 15 pressed in the same frame -> key_pluse=16'h8001 for a single cycle.
REQ-033 Enable: drop scan_en mid-column-2 for 20 cycles -> col_out=4'hF and no pulses while low; after scan_en rises, col_out=4'b1110 on the next cycle.
REQ-034 Repeat: hold key 3 for 12 frames -> with KEYPAD_REPEAT_EN, pulses at press+0, +4, +6, +8 frames; without it, one pulse only.
